// File: rtl/param_fetch_ctrl.sv
// param_fetch_ctrl
// Streams a burst of words from a synchronous parameter ROM into a
// valid/ready interface. Addresses are issued from a registered pointer,
// and the ROM returns each word one clock later. Words land in a small
// FIFO so that downstream back-pressure never loses data. The address
// issuer only runs while every in-flight read is guaranteed a FIFO slot.

module param_fetch_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 10,
    parameter int LEN_WIDTH  = 10
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [ADDR_WIDTH-1:0]        base_addr,
    input  logic [LEN_WIDTH-1:0]         length,
    output logic                         busy,
    output logic                         done,
    output logic [ADDR_WIDTH-1:0]        rom_addr,
    input  logic signed [DATA_WIDTH-1:0] rom_data,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic signed [DATA_WIDTH-1:0] m_data,
    output logic                         m_last
);

    localparam int FIFO_DEPTH = 4;
    localparam int PTR_WIDTH  = 2;
    localparam int CNT_WIDTH  = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_nextState;

    // Address issue pipeline
    logic [ADDR_WIDTH-1:0]  r_romAddr;
    logic [LEN_WIDTH-1:0]   r_remain;
    logic                   r_issue;
    logic                   r_issueLast;
    logic                   r_issueD;
    logic                   r_issueLastD;

    // Output FIFO
    logic [DATA_WIDTH-1:0]  r_fifoData [FIFO_DEPTH];
    logic                   r_fifoLast [FIFO_DEPTH];
    logic [PTR_WIDTH-1:0]   r_wrPtr;
    logic [PTR_WIDTH-1:0]   r_rdPtr;
    logic [CNT_WIDTH-1:0]   r_count;

    // Combinational control
    logic                   w_issue;
    logic                   w_issueFirst;
    logic                   w_issueLast;
    logic                   w_room;
    logic [CNT_WIDTH-1:0]   w_committed;
    logic                   w_write;
    logic                   w_read;
    logic                   w_fifoValid;
    logic                   w_headLast;

    // A FIFO slot is reserved for every read already in flight. A new
    // read may only be issued when one more slot is still free.
    assign w_committed = r_count
                       + {{(CNT_WIDTH-1){1'b0}}, r_issue}
                       + {{(CNT_WIDTH-1){1'b0}}, r_issueD};
    assign w_room      = (w_committed < CNT_WIDTH'(FIFO_DEPTH));

    assign w_fifoValid = (r_count != '0);
    assign w_headLast  = r_fifoLast[r_rdPtr];
    assign w_write     = r_issueD;
    assign w_read      = w_fifoValid && m_ready;

    assign m_valid     = w_fifoValid;
    assign m_data      = w_fifoValid ? r_fifoData[r_rdPtr] : '0;
    assign m_last      = w_fifoValid && w_headLast;
    assign rom_addr    = r_romAddr;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state, address-issue decisions and status outputs
    always_comb begin
        w_nextState  = r_state;
        w_issue      = 1'b0;
        w_issueFirst = 1'b0;
        w_issueLast  = 1'b0;
        busy         = 1'b1;
        done         = 1'b0;

        unique case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    if (length != '0) begin
                        w_issue      = 1'b1;
                        w_issueFirst = 1'b1;
                        w_issueLast  = (length == LEN_WIDTH'(1));
                        w_nextState  = FETCH;
                    end else begin
                        w_nextState  = DONE;
                    end
                end
            end

            FETCH: begin
                if (r_remain == '0) begin
                    // Single-word bursts issue their only address from IDLE
                    w_nextState = DRAIN;
                end else if (w_room) begin
                    w_issue     = 1'b1;
                    w_issueLast = (r_remain == LEN_WIDTH'(1));
                    if (r_remain == LEN_WIDTH'(1)) begin
                        w_nextState = DRAIN;
                    end
                end
            end

            DRAIN: begin
                if (w_read && w_headLast) begin
                    w_nextState = DONE;
                end
            end

            DONE: begin
                done        = 1'b1;
                w_nextState = IDLE;
            end

            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Address pointer, remaining-word counter and the two-stage issue
    // tracker that marks when ROM data is ready to be captured
    always_ff @(posedge clk) begin
        if (rst) begin
            r_romAddr    <= '0;
            r_remain     <= '0;
            r_issue      <= 1'b0;
            r_issueLast  <= 1'b0;
            r_issueD     <= 1'b0;
            r_issueLastD <= 1'b0;
        end else begin
            if (w_issueFirst) begin
                r_romAddr <= base_addr;
                r_remain  <= length - LEN_WIDTH'(1);
            end else if (w_issue) begin
                r_romAddr <= r_romAddr + ADDR_WIDTH'(1);
                r_remain  <= r_remain - LEN_WIDTH'(1);
            end
            r_issue      <= w_issue;
            r_issueLast  <= w_issueLast;
            r_issueD     <= r_issue;
            r_issueLastD <= r_issueLast;
        end
    end

    // FIFO storage; contents need no reset because the count gates them
    always_ff @(posedge clk) begin
        if (w_write) begin
            r_fifoData[r_wrPtr] <= rom_data;
            r_fifoLast[r_wrPtr] <= r_issueLastD;
        end
    end

    // FIFO pointers and occupancy; a write and read together leave the
    // count unchanged
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_write) begin
                r_wrPtr <= r_wrPtr + PTR_WIDTH'(1);
            end
            if (w_read) begin
                r_rdPtr <= r_rdPtr + PTR_WIDTH'(1);
            end
            if (w_write && !w_read) begin
                r_count <= r_count + CNT_WIDTH'(1);
            end else if (w_read && !w_write) begin
                r_count <= r_count - CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_param_fetch_ctrl.sv
// tb_param_fetch_ctrl
// Directed scenarios followed by randomized bursts. A burst request
// pushes the words it should produce (ROM contents at base+i, wrapping)
// into a queue; a monitor pops on every accepted word and checks data,
// last flag, stall stability and the done pulse.

module tb_param_fetch_ctrl;

    localparam int DW = 8;
    localparam int AW = 10;
    localparam int LW = 10;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } expWord_t;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic [AW-1:0]        baseAddr;
    logic [LW-1:0]        lengthIn;
    logic                 busy;
    logic                 done;
    logic [AW-1:0]        romAddr;
    logic signed [DW-1:0] romData;
    logic                 mValid;
    logic                 mReady;
    logic signed [DW-1:0] mData;
    logic                 mLast;

    logic [DW-1:0]        romMem [1 << AW];
    expWord_t             expQ [$];

    int                   compared    = 0;
    int                   mismatched  = 0;
    int                   acceptCount = 0;
    bit                   pendDone    = 1'b0;
    bit                   randReady   = 1'b0;
    bit                   holdValid   = 1'b0;
    logic [DW-1:0]        holdData;
    logic                 holdLast;

    param_fetch_ctrl #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .LEN_WIDTH (LW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .base_addr(baseAddr),
        .length   (lengthIn),
        .busy     (busy),
        .done     (done),
        .rom_addr (romAddr),
        .rom_data (romData),
        .m_valid  (mValid),
        .m_ready  (mReady),
        .m_data   (mData),
        .m_last   (mLast)
    );

    // Clock generation
    always #5 clk = ~clk;

    // Synchronous ROM: data appears one clock after the address is sampled
    always @(posedge clk) begin
        romData <= romMem[romAddr];
    end

    // Random back-pressure while the randomized phase is active
    always @(posedge clk) begin
        #1;
        if (randReady) begin
            mReady = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: judges what will happen at the following rising edge
    always @(negedge clk) begin
        expWord_t w;
        if (rst !== 1'b0) begin
            holdValid = 1'b0;
        end else begin
            checkOutput("donePulse", {31'd0, done}, {31'd0, pendDone});
            pendDone = 1'b0;
            if (holdValid) begin
                checkOutput("stallValid", {31'd0, mValid}, 32'd1);
                checkOutput("stallData", {{(32-DW){1'b0}}, mData}, {{(32-DW){1'b0}}, holdData});
                checkOutput("stallLast", {31'd0, mLast}, {31'd0, holdLast});
            end
            holdValid = 1'b0;
            if (mValid === 1'b1) begin
                if (mReady) begin
                    if (expQ.size() == 0) begin
                        compared++;
                        mismatched++;
                        $display("[TB] FAIL unexpectedWord: actual=0x%0h required=no word at %0t", mData, $time);
                    end else begin
                        w = expQ.pop_front();
                        checkOutput("streamData", {{(32-DW){1'b0}}, mData}, {{(32-DW){1'b0}}, w.data});
                        checkOutput("streamLast", {31'd0, mLast}, {31'd0, w.last});
                        acceptCount++;
                        if (w.last) begin
                            pendDone = 1'b1;
                        end
                    end
                end else begin
                    holdValid = 1'b1;
                    holdData  = mData;
                    holdLast  = mLast;
                end
            end
        end
    end

    // Request a burst and record the words the model says it must produce
    task automatic applyStimulus(input logic [AW-1:0] base, input logic [LW-1:0] len);
        expWord_t      w;
        logic [AW-1:0] a;
        for (int i = 0; i < int'(len); i++) begin
            a      = base + AW'(i);
            w.data = romMem[a];
            w.last = (i == int'(len) - 1);
            expQ.push_back(w);
        end
        baseAddr = base;
        lengthIn = len;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (len == '0) begin
            pendDone = 1'b1;
        end
    endtask

    // A request made while busy; the model expects no effect
    task automatic pulseIgnoredStart(input logic [AW-1:0] base, input logic [LW-1:0] len);
        checkOutput("busyAtIgnoredStart", {31'd0, busy}, 32'd1);
        baseAddr = base;
        lengthIn = len;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Issue order and first-word latency with the consumer always ready
    task automatic checkAddrSeq(input logic [AW-1:0] base, input int n);
        logic [AW-1:0] a;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            a = base + AW'(i);
            checkOutput("romAddrSeq", {{(32-AW){1'b0}}, romAddr}, {{(32-AW){1'b0}}, a});
            if (i < 2) begin
                checkOutput("firstValidLatency", {31'd0, mValid}, 32'd0);
            end else begin
                checkOutput("streamThroughput", {31'd0, mValid}, 32'd1);
            end
        end
    endtask

    task automatic waitDone(input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (done !== 1'b1 && n < budget);
        if (done !== 1'b1) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL doneTimeout: actual=no done after %0d cycles required=done pulse", budget);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic checkAllZero(input string name);
        checkOutput({name, "_busy"},    {31'd0, busy},   32'd0);
        checkOutput({name, "_done"},    {31'd0, done},   32'd0);
        checkOutput({name, "_mValid"},  {31'd0, mValid}, 32'd0);
        checkOutput({name, "_mLast"},   {31'd0, mLast},  32'd0);
        checkOutput({name, "_romAddr"}, {{(32-AW){1'b0}}, romAddr}, 32'd0);
        checkOutput({name, "_mData"},   {{(32-DW){1'b0}}, mData},   32'd0);
    endtask

    // Watchdog
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: actual=simulation still running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [AW-1:0] oldAddr;
        logic [AW-1:0] rb;
        logic [LW-1:0] rl;
        int            acceptBase;

        for (int i = 0; i < (1 << AW); i++) begin
            romMem[i] = DW'($urandom);
        end
        rst      = 1'b1;
        start    = 1'b0;
        baseAddr = '0;
        lengthIn = '0;
        mReady   = 1'b0;

        // Reset state, including reset winning over a simultaneous start
        repeat (3) @(posedge clk);
        #1;
        baseAddr = AW'(10'h0AA);
        lengthIn = LW'(3);
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        checkAllZero("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkAllZero("afterReset");
        @(posedge clk);
        #1;

        // Basic burst of four words
        mReady = 1'b1;
        applyStimulus(AW'(10'h010), LW'(4));
        checkAddrSeq(AW'(10'h010), 4);
        waitDone(50);

        // Zero-length request
        oldAddr = romAddr;
        applyStimulus(AW'(10'h155), LW'(0));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("zeroLenValid", {31'd0, mValid}, 32'd0);
            checkOutput("zeroLenAddr", {{(32-AW){1'b0}}, romAddr}, {{(32-AW){1'b0}}, oldAddr});
        end
        checkOutput("zeroLenIdle", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;

        // Long stall: only four reads may be outstanding
        mReady = 1'b0;
        applyStimulus(AW'(10'h100), LW'(8));
        repeat (10) @(negedge clk);
        checkOutput("stallIssueCount", {{(32-AW){1'b0}}, romAddr}, 32'h103);
        checkOutput("stallHasWord", {31'd0, mValid}, 32'd1);
        @(posedge clk);
        #1;
        mReady = 1'b1;
        waitDone(100);

        // Address wrap at the top of the ROM
        applyStimulus(AW'(10'h3FE), LW'(4));
        checkAddrSeq(AW'(10'h3FE), 4);
        waitDone(50);

        // Start while busy is ignored
        applyStimulus(AW'(10'h020), LW'(6));
        pulseIgnoredStart(AW'(10'h200), LW'(3));
        waitDone(100);
        checkOutput("ignoredStartAddr", {{(32-AW){1'b0}}, romAddr}, 32'h025);

        // Reset after the second word of a six-word burst
        acceptBase = acceptCount;
        applyStimulus(AW'(10'h050), LW'(6));
        repeat (4) @(posedge clk);
        #1;
        checkOutput("acceptsBeforeReset", acceptCount - acceptBase, 32'd2);
        rst = 1'b1;
        expQ.delete();
        pendDone = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkAllZero("midBurstReset");
        repeat (4) @(negedge clk);
        checkOutput("noDoneAfterAbort", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
        applyStimulus(AW'(10'h300), LW'(2));
        checkAddrSeq(AW'(10'h300), 2);
        waitDone(50);

        // Randomized bursts under random back-pressure
        randReady = 1'b1;
        for (int b = 0; b < 25; b++) begin
            rb = AW'($urandom);
            rl = LW'($urandom_range(0, 12));
            applyStimulus(rb, rl);
            if (rl == '0) begin
                @(negedge clk);
                @(posedge clk);
                #1;
            end else begin
                if ($urandom_range(0, 1) == 1) begin
                    pulseIgnoredStart(AW'($urandom), LW'($urandom_range(1, 12)));
                end
                waitDone(400);
            end
        end
        randReady = 1'b0;
        mReady    = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        checkOutput("scoreboardEmpty", expQ.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
